// File: rtl/floppy_driver.sv
// floppy_driver: STEP/DIR generator bouncing one floppy head between 0 and MAX_TRACK.
// Define FLOPPY_DRIVER_HOME_EN to include the post-reset homing sequence.
module floppy_driver #(
   parameter int MAX_TRACK   = 79,
   parameter int HOME_PERIOD = 250000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [21:0] sp,
   input  logic        en,
   output logic        step,
   output logic        dir,
   output logic [6:0]  track,
   output logic        homing
);

   typedef enum logic [1:0] {
      HOME = 2'd0,
      IDLE = 2'd1,
      PLAY = 2'd2
   } state_t;

   localparam logic [6:0] MAX = 7'(MAX_TRACK);

   state_t      state;
   logic [21:0] cnt;
   logic        go;
   logic        tc;
   logic        fall;
   logic [6:0]  nt;

   if (HOME_PERIOD < 1) begin : g_bad_home_period
   end

`ifdef FLOPPY_DRIVER_HOME_EN
   localparam int HW = (HOME_PERIOD > 1) ? $clog2(HOME_PERIOD) : 1;
   localparam logic [HW-1:0] HLAST = HW'(HOME_PERIOD - 1);
   localparam logic [7:0] TLAST = 8'(2 * (MAX_TRACK + 1) - 1);
   logic [HW-1:0] hcnt;
   logic [7:0]    htog;
`else
   assign homing = 1'b0;
`endif

   // Play request, terminal count, falling STEP edge and next track.
   always_comb begin
      go   = en && (sp != 22'd0);
      tc   = cnt >= (sp - 22'd1);
      fall = step && (!go || tc);
      nt   = dir ? (track - 7'd1) : (track + 7'd1);
   end

   // Main FSM: homing, idle wait, and tone playback with head bounce.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step  <= 1'b0;
         track <= 7'd0;
         cnt   <= 22'd0;
`ifdef FLOPPY_DRIVER_HOME_EN
         state  <= HOME;
         dir    <= 1'b1;
         homing <= 1'b1;
         hcnt   <= '0;
         htog   <= 8'd0;
`else
         state <= IDLE;
         dir   <= 1'b0;
`endif
      end else begin
         unique case (state)
`ifdef FLOPPY_DRIVER_HOME_EN
            HOME: begin
               if (hcnt == HLAST) begin
                  hcnt <= '0;
                  step <= ~step;
                  htog <= htog + 8'd1;
                  if (htog == TLAST) begin
                     step   <= 1'b0;
                     dir    <= 1'b0;
                     homing <= 1'b0;
                     state  <= IDLE;
                  end
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end
`endif
            IDLE: begin
               step <= 1'b0;
               cnt  <= 22'd0;
               if (go) state <= PLAY;
            end
            PLAY: begin
               if (!go) begin
                  state <= IDLE;
                  step  <= 1'b0;
                  cnt   <= 22'd0;
               end else if (tc) begin
                  cnt  <= 22'd0;
                  step <= ~step;
               end else begin
                  cnt <= cnt + 22'd1;
               end
               // A falling STEP (natural or forced by exit) moves the head.
               if (fall) begin
                  track <= nt;
                  if (nt == MAX) dir <= 1'b1;
                  else if (nt == 7'd0) dir <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               step  <= 1'b0;
               cnt   <= 22'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_floppy_driver.sv
// tb_floppy_driver: directed checks of homing, play, bounce, exit, setpoint change, reset.
// Works with or without FLOPPY_DRIVER_HOME_EN defined.
module tb_floppy_driver;

   localparam int MT = 3;
   localparam int HP = 4;

`ifdef FLOPPY_DRIVER_HOME_EN
   localparam logic RST_DIR = 1'b1;
   localparam logic RST_HOM = 1'b1;
`else
   localparam logic RST_DIR = 1'b0;
   localparam logic RST_HOM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [21:0] sp  = 22'd0;
   logic        en  = 1'b0;
   logic        step;
   logic        dir;
   logic [6:0]  track;
   logic        homing;

   int checks   = 0;
   int failures = 0;

   floppy_driver #(.MAX_TRACK(MT), .HOME_PERIOD(HP)) dut (
      .clk(clk), .rst(rst), .sp(sp), .en(en),
      .step(step), .dir(dir), .track(track), .homing(homing)
   );

   always #5 clk = ~clk;

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; sp = 22'd0;
      edges(3);
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL rst_step got %0d exp 0", step); end
      checks++; if (track !== 7'd0) begin failures++; $display("FAIL rst_track got %0d exp 0", track); end
      checks++; if (dir !== RST_DIR) begin failures++; $display("FAIL rst_dir got %0d exp %0d", dir, RST_DIR); end
      checks++; if (homing !== RST_HOM) begin failures++; $display("FAIL rst_homing got %0d exp %0d", homing, RST_HOM); end
   endtask

   task automatic test_homing;
      logic es, eh;
      rst = 1'b0;
`ifdef FLOPPY_DRIVER_HOME_EN
      for (int k = 1; k <= 32; k++) begin
         edges(1);
         es = 1'((k / 4) % 2);
         eh = (k < 32);
         checks++; if (step !== es) begin failures++; $display("FAIL home_step k=%0d got %0d exp %0d", k, step, es); end
         checks++; if (homing !== eh) begin failures++; $display("FAIL home_homing k=%0d got %0d exp %0d", k, homing, eh); end
         checks++; if (dir !== eh) begin failures++; $display("FAIL home_dir k=%0d got %0d exp %0d", k, dir, eh); end
         checks++; if (track !== 7'd0) begin failures++; $display("FAIL home_track k=%0d got %0d exp 0", k, track); end
      end
`else
      for (int k = 1; k <= 5; k++) begin
         edges(1);
         es = 1'b0; eh = 1'b0;
         checks++; if (step !== es) begin failures++; $display("FAIL idle_step k=%0d got %0d exp 0", k, step); end
         checks++; if (homing !== eh) begin failures++; $display("FAIL idle_homing k=%0d got %0d exp 0", k, homing); end
         checks++; if (dir !== 1'b0) begin failures++; $display("FAIL idle_dir k=%0d got %0d exp 0", k, dir); end
      end
`endif
   endtask

   task automatic test_play_bounce;
      int tr[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
      int dr[8] = '{0, 0, 1, 1, 1, 0, 0, 0};
      logic es;
      int idx;
      sp = 22'd5; en = 1'b1;
      for (int k = 1; k <= 86; k++) begin
         edges(1);
         es = 1'(((k - 1) / 5) % 2);
         checks++; if (step !== es) begin failures++; $display("FAIL play_step k=%0d got %0d exp %0d", k, step, es); end
         if (k > 1 && (k - 1) % 10 == 0) begin
            idx = (k - 1) / 10 - 1;
            checks++; if (track !== 7'(tr[idx])) begin failures++; $display("FAIL bounce_track k=%0d got %0d exp %0d", k, track, tr[idx]); end
            checks++; if (dir !== 1'(dr[idx])) begin failures++; $display("FAIL bounce_dir k=%0d got %0d exp %0d", k, dir, dr[idx]); end
         end
      end
   endtask

   task automatic test_exit_mid_pulse;
      en = 1'b0;
      edges(1);
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL exit_step got %0d exp 0", step); end
      checks++; if (track !== 7'd3) begin failures++; $display("FAIL exit_track got %0d exp 3", track); end
      checks++; if (dir !== 1'b1) begin failures++; $display("FAIL exit_dir got %0d exp 1", dir); end
      edges(2);
      checks++; if (track !== 7'd3) begin failures++; $display("FAIL idle_hold_track got %0d exp 3", track); end
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL idle_hold_step got %0d exp 0", step); end
      en = 1'b1;
      edges(5);
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL reen_step5 got %0d exp 0", step); end
      edges(1);
      checks++; if (step !== 1'b1) begin failures++; $display("FAIL reen_step6 got %0d exp 1", step); end
      checks++; if (track !== 7'd3) begin failures++; $display("FAIL reen_track6 got %0d exp 3", track); end
      edges(5);
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL reen_step11 got %0d exp 0", step); end
      checks++; if (track !== 7'd2) begin failures++; $display("FAIL reen_track11 got %0d exp 2", track); end
      checks++; if (dir !== 1'b1) begin failures++; $display("FAIL reen_dir11 got %0d exp 1", dir); end
      en = 1'b0;
      edges(1);
      checks++; if (track !== 7'd2) begin failures++; $display("FAIL stop_track got %0d exp 2", track); end
   endtask

   task automatic test_setpoint_change;
      logic es;
      sp = 22'd100; en = 1'b1;
      edges(51);
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL sp100_step got %0d exp 0", step); end
      sp = 22'd3;
      for (int j = 1; j <= 7; j++) begin
         edges(1);
         es = (j < 4) ? 1'b1 : ((j < 7) ? 1'b0 : 1'b1);
         checks++; if (step !== es) begin failures++; $display("FAIL sp3_step j=%0d got %0d exp %0d", j, step, es); end
         if (j == 4) begin
            checks++; if (track !== 7'd1) begin failures++; $display("FAIL sp3_track got %0d exp 1", track); end
            checks++; if (dir !== 1'b1) begin failures++; $display("FAIL sp3_dir got %0d exp 1", dir); end
         end
      end
   endtask

   task automatic test_async_reset;
      #2 rst = 1'b1;
      #1;
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL arst_step got %0d exp 0", step); end
      checks++; if (track !== 7'd0) begin failures++; $display("FAIL arst_track got %0d exp 0", track); end
      checks++; if (dir !== RST_DIR) begin failures++; $display("FAIL arst_dir got %0d exp %0d", dir, RST_DIR); end
      checks++; if (homing !== RST_HOM) begin failures++; $display("FAIL arst_homing got %0d exp %0d", homing, RST_HOM); end
      @(negedge clk);
      rst = 1'b0;
      edges(3);
      checks++; if (step !== 1'b0) begin failures++; $display("FAIL rel_step3 got %0d exp 0", step); end
      edges(1);
      checks++; if (step !== 1'b1) begin failures++; $display("FAIL rel_step4 got %0d exp 1", step); end
      checks++; if (homing !== RST_HOM) begin failures++; $display("FAIL rel_homing got %0d exp %0d", homing, RST_HOM); end
      checks++; if (dir !== RST_DIR) begin failures++; $display("FAIL rel_dir got %0d exp %0d", dir, RST_DIR); end
      checks++; if (track !== 7'd0) begin failures++; $display("FAIL rel_track got %0d exp 0", track); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_homing();
      test_play_bounce();
      test_exit_mid_pulse();
      test_setpoint_change();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/floppy_driver.md
# floppy_driver

Per-drive step/direction generator that turns a note setpoint into audible head motion on one floppy drive. It sits directly downstream of the register controller and consumes its `f0_sp` setpoint and `f0_en` enable. It toggles the drive STEP line every `sp` clock cycles and bounces the head between track 0 and `MAX_TRACK`. After reset it homes the head to track 0, so the direction logic starts from a known position.

## Interface

Parameters:
- `MAX_TRACK`, default 79: highest track index; must be in 1..127.
- `HOME_PERIOD`, default 250000: clk cycles between STEP toggles while homing (5 ms at 50 MHz).

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `sp`  in  22: half-period of the STEP waveform in clk cycles; 0 means silent.
- `en`  in  1: play enable.
- `step`  out  1: drive STEP line, logical active-high, registered.
- `dir`  out  1: head direction, registered; 0 = toward `MAX_TRACK`, 1 = toward track 0.
- `track`  out  7: current head track, registered.
- `homing`  out  1: high while the homing sequence runs.

## Operation

- State machine: HOME, IDLE, PLAY. Period counter `cnt` is 22 bits.
- **HOME:**
  - `dir`=1, `track` held at 0, and `en`/`sp` are ignored.
  - `step` toggles every `HOME_PERIOD` cycles.
  - After 2*(MAX_TRACK+1) toggles, the last of which leaves `step`=0, the block sets `dir`<=0 and `homing`<=0 and goes to IDLE.
- **IDLE:**
  - `step`=0 and `cnt`=0.
  - Goes to PLAY on the first cycle with `en`=1 and `sp`!=0.
- **PLAY:**
  - Each cycle `cnt` increments.
  - When `cnt` >= `sp`-1, `cnt`<=0 and `step` toggles. The >= test makes a lowered `sp` take effect on the next cycle without a wrap through 2^22.
  - On every 1->0 transition of `step`, the head has moved one track: `track` moves by ±1 according to `dir`.
  - If the new `track` equals `MAX_TRACK`, `dir`<=1. If the new `track` equals 0, `dir`<=0. `dir` changes in the same cycle as the `track` update.
- **PLAY exit:**
  - The block leaves PLAY for IDLE when `en`=0 or `sp`=0.
  - `step`<=0 and `cnt`<=0.
  - If `step` was 1, that forced falling edge counts as a step: `track` and `dir` update exactly as above.
  - `track` and `dir` are retained across IDLE.
- **Simultaneous events:** a terminal count and an exit in the same cycle resolve as the exit. `step` ends at 0, and at most one track update occurs.
- **Reset:** `rst` asserted at any time, including mid-PLAY or mid-HOME, immediately forces the reset values. The homing sequence restarts on release.

## Timing

- **Reset values:**
  - `step`=0 and `track`=0.
  - With homing compiled in: `dir`=1, `homing`=1, state HOME.
  - Without homing: `dir`=0, `homing`=0, state IDLE.
  - `cnt`=0 in both cases.
- **PLAY entry:** `en`/`sp` are sampled at edge N and PLAY is entered at edge N+1. The first `step` rise occurs `sp` cycles after PLAY entry.
- **Waveform:** the STEP period is 2*`sp` cycles, so the tone is clk/(2*sp).
- **Track updates:** `track` updates on the same edge as the `step` 1->0 transition.
- **HOME step timing:** the first HOME toggle occurs `HOME_PERIOD` cycles after reset release. `homing` falls on the same edge as the final toggle.
- **HOME to PLAY:** IDLE lasts at least one cycle, so with `en`=1 already high, PLAY begins two edges after `homing` falls.
- **Output registration:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- Macro `FLOPPY_DRIVER_HOME_EN`:
  - **Defined:** HOME state present. Reset enters HOME as described above.
  - **Undefined:** HOME logic and the `HOME_PERIOD` counter are removed. Reset enters IDLE with `track`=0 and `dir`=0, and `homing` is tied to 0.

## Test plan

- **Homing:** HOME_EN defined, `HOME_PERIOD`=4, `MAX_TRACK`=3, release `rst` -> 8 `step` toggles spaced 4 cycles, `dir`=1 and `homing`=1 throughout; after the 8th toggle `homing`=0, `dir`=0, `step`=0.
- **Basic play:** after homing, `en`=1, `sp`=5 -> `step` rises 5 cycles after PLAY entry, period 10 cycles, and `track` increments 0->1 on the first falling edge.
- **Bounce:** `MAX_TRACK`=3, continuous play -> `track` sequence 1,2,3 with `dir`->1 at 3, then 2,1,0 with `dir`->0 at 0, repeating.
- **Exit mid-pulse:** drop `en` while `step`=1 at `track`=2, `dir`=0 -> next edge `step`=0, `track`=3, `dir`=1, `cnt`=0. Re-enable: the next step moves toward 0.
- **Setpoint change:** with `sp`=100 and `cnt`=50, write `sp`=3 -> `step` toggles on the next edge, then every 3 cycles.
- **Async reset mid-play:** assert `rst` asynchronously mid-PLAY -> `step`=0, `track`=0, `dir`=1, `homing`=1 before the next clk edge; homing restarts on release.
